// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported, variable-latency memory between the instruction
// fetch port (I) and the load/store data port (D) of the RV32I core.
//
// Each access is serialised through three phases:
//   IDLE  - sample requests and grant one port
//   BUSY  - hold the memory command until m_ack arrives or the watchdog expires
//   RESP  - pulse the owner's ready for one cycle
//
// When both ports request in the same IDLE cycle, the port that was not served
// last wins. A watchdog aborts an access after TIMEOUT+1 BUSY cycles without
// m_ack. The aborted access still completes, with err flagged alongside ready.
//
// Every output is driven straight from a flop.
//
// Parameters
//   DATA_WIDTH  data bus width in bits
//   ADDR_WIDTH  address width in bits
//   TIMEOUT     BUSY cycles tolerated without m_ack before aborting (>= 1)
//
// Ports
//   clk, rst                         clock; asynchronous active-high reset
//   i_req, i_addr                    fetch request and address
//   i_rdata, i_ready                 fetched word and one-cycle completion pulse
//   d_req, d_we, d_addr,
//   d_wdata, d_be                    data request, store flag and command
//   d_rdata, d_ready                 load data and one-cycle completion pulse
//   err                              marks a completion caused by the watchdog
//   m_req, m_we, m_addr,
//   m_wdata, m_be                    memory command, held for the whole access
//   m_ack, m_rdata                   memory completion; read data in same cycle
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    // instruction fetch port
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_ready,
    // load/store data port
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_ready,
    output logic                    err,
    // backing memory
    output logic                    m_req,
    output logic                    m_we,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_be,
    input  logic                    m_ack,
    input  logic [DATA_WIDTH-1:0]   m_rdata
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);

    // Port identifiers. They also index the per-port ready and capture vectors.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic                   owner_reg, owner_next;
    logic                   last_reg, last_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;

    logic                   m_req_reg, m_req_next;
    logic                   m_we_reg, m_we_next;
    logic [ADDR_WIDTH-1:0]  m_addr_reg, m_addr_next;
    logic [DATA_WIDTH-1:0]  m_wdata_reg, m_wdata_next;
    logic [BE_WIDTH-1:0]    m_be_reg, m_be_next;
    logic                   err_reg, err_next;

    // Per-port controls, indexed by PORT_I / PORT_D.
    logic [1:0]             ready_next;
    logic [1:0]             capture;

    logic                   any_req;
    logic                   grant_d;
    logic                   timeout_hit;

    assign any_req = i_req | d_req;

    // Data wins when it is the only requester. On a tie it wins only if fetch
    // was served last.
    assign grant_d = d_req & (~i_req | (last_reg == PORT_I));

    // The counter is cleared on grant and advances once per BUSY cycle without
    // an ack. Reaching TIMEOUT therefore means the (TIMEOUT+1)-th silent cycle.
    assign timeout_hit = (cnt_reg == CNT_WIDTH'(TIMEOUT));

    // ------------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (m_ack || timeout_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM process 3: output / datapath next values
    // Everything computed here is registered below, so no output is
    // combinational from an input.
    // ------------------------------------------------------------------------
    always_comb begin
        owner_next   = owner_reg;
        last_next    = last_reg;
        cnt_next     = cnt_reg;
        m_req_next   = m_req_reg;
        m_we_next    = m_we_reg;
        m_addr_next  = m_addr_reg;
        m_wdata_next = m_wdata_reg;
        m_be_next    = m_be_reg;
        err_next     = 1'b0;
        ready_next   = 2'b00;
        capture      = 2'b00;

        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    m_req_next = 1'b1;
                    cnt_next   = '0;
                    if (grant_d) begin
                        owner_next   = PORT_D;
                        m_we_next    = d_we;
                        m_addr_next  = d_addr;
                        m_wdata_next = d_wdata;
                        m_be_next    = d_be;
                    end else begin
                        // A fetch is always a full-word read.
                        owner_next   = PORT_I;
                        m_we_next    = 1'b0;
                        m_addr_next  = i_addr;
                        m_wdata_next = '0;
                        m_be_next    = '1;
                    end
                end
            end
            ST_BUSY: begin
                if (m_ack) begin
                    // An ack in the last watchdog cycle still counts as a
                    // normal completion.
                    m_req_next            = 1'b0;
                    ready_next[owner_reg] = 1'b1;
                    capture[owner_reg]    = ~m_we_reg;
                end else if (timeout_hit) begin
                    // Abort without touching the owner's read data.
                    m_req_next            = 1'b0;
                    ready_next[owner_reg] = 1'b1;
                    err_next              = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_WIDTH'(1);
                end
            end
            ST_RESP: begin
                last_next = owner_reg;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Control and memory command registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_reg   <= PORT_I;
            last_reg    <= PORT_I;
            cnt_reg     <= '0;
            m_req_reg   <= 1'b0;
            m_we_reg    <= 1'b0;
            m_addr_reg  <= '0;
            m_wdata_reg <= '0;
            m_be_reg    <= '0;
            err_reg     <= 1'b0;
        end else begin
            owner_reg   <= owner_next;
            last_reg    <= last_next;
            cnt_reg     <= cnt_next;
            m_req_reg   <= m_req_next;
            m_we_reg    <= m_we_next;
            m_addr_reg  <= m_addr_next;
            m_wdata_reg <= m_wdata_next;
            m_be_reg    <= m_be_next;
            err_reg     <= err_next;
        end
    end

    // ------------------------------------------------------------------------
    // Per-port response registers: gi = 0 is fetch, gi = 1 is data.
    // Each read-data register changes only on a captured ack for its own port,
    // so it holds its value across stores, timeouts and idle periods.
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_WIDTH-1:0] rdata_reg;
            logic                  ready_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_reg <= '0;
                    ready_reg <= 1'b0;
                end else begin
                    ready_reg <= ready_next[gi];
                    if (capture[gi]) begin
                        rdata_reg <= m_rdata;
                    end
                end
            end

            if (gi == 0) begin : g_fetch_out
                assign i_rdata = rdata_reg;
                assign i_ready = ready_reg;
            end else begin : g_data_out
                assign d_rdata = rdata_reg;
                assign d_ready = ready_reg;
            end
        end
    endgenerate

    assign err     = err_reg;
    assign m_req   = m_req_reg;
    assign m_we    = m_we_reg;
    assign m_addr  = m_addr_reg;
    assign m_wdata = m_wdata_reg;
    assign m_be    = m_be_reg;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing a single-ported, variable-latency main memory between the instruction-fetch port and the load/store data port of the RV32I core. It sits between the fetch/memory stages and the backing memory. It serialises accesses with a registered request/acknowledge handshake and arbitrates fairly under contention. A watchdog terminates accesses the memory never acknowledges.

## Interface
- DATA_WIDTH, 32, data bus width in bits.
- ADDR_WIDTH, 32, address width in bits.
- TIMEOUT, 255, maximum BUSY cycles without m_ack before the access is aborted; must be ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held with i_addr stable until i_ready.
- i_addr  in  ADDR_WIDTH  fetch address.
- i_rdata  out  DATA_WIDTH  fetched word; valid while i_ready=1.
- i_ready  out  1  one-cycle completion pulse for the fetch port.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be stable until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_be  in  DATA_WIDTH/8  store byte enables.
- d_rdata  out  DATA_WIDTH  load data; valid while d_ready=1 for a load.
- d_ready  out  1  one-cycle completion pulse for the data port.
- err  out  1  high together with i_ready or d_ready when that access timed out.
- m_req, m_we  out  1 each  memory request and write enable.
- m_addr  out  ADDR_WIDTH; m_wdata  out  DATA_WIDTH; m_be  out  DATA_WIDTH/8  memory command.
- m_ack  in  1  memory completion; m_rdata is valid in the same cycle.
- m_rdata  in  DATA_WIDTH  memory read data.

## Operation
- FSM states: IDLE, BUSY, RESP. Register owner ∈ {I, D}, register last ∈ {I, D}, and a timeout counter of width clog2(TIMEOUT+1).
- IDLE: no request pending → stay. Exactly one request → grant it. Both requests → grant the port ≠ last.
  - On grant: latch owner and the full command (m_we forced to 0 for I); set m_req=1; clear the counter; go to BUSY.
- BUSY: m_req and the command are held stable.
  - m_ack=1 → capture m_rdata into the owner's rdata register (loads and fetches only); go to RESP.
  - Otherwise, counter reaches TIMEOUT → set err; go to RESP. Rdata is left unchanged.
  - Otherwise, increment the counter.
  - m_req deasserts on the transition out of BUSY.
- RESP: owner's ready=1 for exactly one cycle; err is as set in BUSY; last←owner; go to IDLE.
- Requester dropping req while granted is illegal. The arbiter completes the access anyway and still pulses ready.
- Stores do not update d_rdata. rdata registers hold their value between accesses.
- A requester that keeps req high in the cycle after ready is issuing a new request, sampled in IDLE.
- m_ack outside BUSY is ignored.

## Timing
- All outputs are registered.
- Reset value: every output is 0; state=IDLE; last=I, so data wins the first tie.
- Reset is asynchronous: m_req and both ready outputs drop immediately, even mid-BUSY. The in-flight access is discarded and no ready is produced.
- Latency: req sampled at edge 0 → m_req high in cycle 1. m_ack in cycle 1+k → ready in cycle 2+k. Minimum is 2 cycles request-to-ready.
- Maximum throughput is one access per 3 cycles.
- Timeout: with no ack, ready+err appear TIMEOUT+2 cycles after the request is sampled.
- Contention: with both ports continuously requesting, grants strictly alternate.

## Test plan
- Single fetch: i_req=1, i_addr=0x0000_0010; memory acks in the first BUSY cycle with 0x0050_0093 → m_req high 1 cycle, i_ready=1 with i_rdata=0x0050_0093 two cycles after request, d_ready stays 0.
- Simultaneous request after reset: i_req=d_req=1 (load 0x104, memory returns 0xDEAD_BEEF after 3 wait cycles) → data served first (d_rdata=0xDEAD_BEEF), then fetch; i_ready follows d_ready by 3 cycles with zero-wait fetch.
- Sustained contention over 6 accesses → grant order D,I,D,I,D,I; m_we=1 only on data grants when d_we=1.
- Store: d_we=1, d_addr=0x200, d_wdata=0x1234_5678, d_be=4'b0011 → m_we=1, m_be=0011, m_wdata=0x1234_5678 held until ack; d_ready pulses; d_rdata unchanged.
- Timeout with TIMEOUT=4: fetch request, m_ack never asserted → i_ready=1 and err=1 in the same cycle, 6 cycles after request; i_rdata unchanged; next request served normally with err=0.
- Reset mid-BUSY: assert rst during BUSY before ack → all outputs 0 asynchronously. After release, a late m_ack is ignored, and a new i_req completes normally.
